// File: rtl/regbank_seq_pkg.sv
// Shared types and defaults for the regbank_seq sequencer.
// Optional flag logic is enabled with REGBANK_SEQ_FLAGS_EN.
package regbank_seq_pkg;

    localparam int DW_DEF = 8;
    localparam int AW_DEF = 3;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_SHL = 3'd5,
        OP_LDI = 3'd6,
        OP_CMP = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2
    } state_e;

endpackage

// File: rtl/regbank_alu.sv
// Combinational ALU for the sequencer EXEC stage.
// Carry logic only exists when REGBANK_SEQ_FLAGS_EN is defined.
module regbank_alu
    import regbank_seq_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  op_e           op,
    input  logic [DW-1:0] d1,
    input  logic [DW-1:0] d2,
    input  logic [DW-1:0] imm,
    output logic [DW-1:0] result,
    output logic          carry
);

    always_comb begin
        result = '0;
        carry  = 1'b0;
        unique case (op)
            OP_ADD: {carry, result} = {1'b0, d1} + {1'b0, d2};
            OP_SUB,
            OP_CMP: begin
                result = d1 - d2;
                carry  = (d1 < d2);
            end
            OP_AND: result = d1 & d2;
            OP_OR:  result = d1 | d2;
            OP_XOR: result = d1 ^ d2;
            OP_SHL: begin
                result = {d1[DW-2:0], 1'b0};
                carry  = d1[DW-1];
            end
            OP_LDI: result = imm;
            default: result = '0;
        endcase
`ifndef REGBANK_SEQ_FLAGS_EN
        carry = 1'b0;
`endif
    end

endmodule

// File: rtl/regbank_seq.sv
// Three-cycle instruction sequencer driving an 8x8 register bank.
// Optional zero/carry flags are enabled with REGBANK_SEQ_FLAGS_EN.
module regbank_seq
    import regbank_seq_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic          clkg,
    input  logic          rst,
    input  logic          instr_valid,
    output logic          instr_ready,
    input  logic [2:0]    op,
    input  logic [AW-1:0] rd,
    input  logic [AW-1:0] rs,
    input  logic [AW-1:0] rs2,
    input  logic [DW-1:0] imm,
    output logic [AW-1:0] bank_rs_o,
    output logic [AW-1:0] bank_rs2_o,
    input  logic [DW-1:0] bank_d1_i,
    input  logic [DW-1:0] bank_d2_i,
    output logic [AW-1:0] bank_rd_o,
    output logic [DW-1:0] bank_dat_o,
    output logic          bank_we_o,
    output logic          done,
    output logic [DW-1:0] res_o,
    output logic          zero_o,
    output logic          carry_o
);

    state_e        state;
    state_e        nxt;
    op_e           op_q;
    logic [AW-1:0] rd_q;
    logic [AW-1:0] rs_q;
    logic [AW-1:0] rs2_q;
    logic [DW-1:0] imm_q;
    logic [DW-1:0] res_q;
    logic [DW-1:0] alu_res;
    logic          alu_carry;
    logic          accept;

    assign accept = instr_valid && instr_ready;

    always_ff @(posedge clkg or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt         = state;
        instr_ready = 1'b0;
        bank_we_o   = 1'b0;
        done        = 1'b0;
        unique case (state)
            S_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) nxt = S_EXEC;
            end
            S_EXEC: nxt = S_WB;
            S_WB: begin
                bank_we_o = (op_q != OP_CMP);
                done      = 1'b1;
                nxt       = S_IDLE;
            end
            default: nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clkg or posedge rst) begin
        if (rst) begin
            op_q  <= OP_ADD;
            rd_q  <= '0;
            rs_q  <= '0;
            rs2_q <= '0;
            imm_q <= '0;
        end else if (accept) begin
            op_q  <= op_e'(op);
            rd_q  <= rd;
            rs_q  <= rs;
            rs2_q <= rs2;
            imm_q <= imm;
        end
    end

    regbank_alu #(.DW(DW)) u_alu (
        .op     (op_q),
        .d1     (bank_d1_i),
        .d2     (bank_d2_i),
        .imm    (imm_q),
        .result (alu_res),
        .carry  (alu_carry)
    );

    always_ff @(posedge clkg or posedge rst) begin
        if (rst)                  res_q <= '0;
        else if (state == S_EXEC) res_q <= alu_res;
    end

`ifdef REGBANK_SEQ_FLAGS_EN
    logic zero_q;
    logic carry_q;

    // LDI is a move, not an arithmetic op, so it keeps the old flags
    always_ff @(posedge clkg or posedge rst) begin
        if (rst) begin
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
        end else if (state == S_EXEC && op_q != OP_LDI) begin
            zero_q  <= (alu_res == '0);
            carry_q <= alu_carry;
        end
    end

    assign zero_o  = zero_q;
    assign carry_o = carry_q;
`else
    logic unused_carry;
    assign unused_carry = alu_carry;
    assign zero_o       = 1'b0;
    assign carry_o      = 1'b0;
`endif

    assign bank_rs_o  = rs_q;
    assign bank_rs2_o = rs2_q;
    assign bank_rd_o  = rd_q;
    assign bank_dat_o = res_q;
    assign res_o      = res_q;

endmodule

// File: tb/tb_regbank_seq.sv
// Scoreboard bench for regbank_seq with a behavioural register-file model.
// Flag expectations follow REGBANK_SEQ_FLAGS_EN.
module tb_regbank_seq;

`ifdef REGBANK_SEQ_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    logic       clkg = 1'b0;
    logic       rst;
    logic       instr_valid;
    logic       instr_ready;
    logic [2:0] op;
    logic [2:0] rd;
    logic [2:0] rs;
    logic [2:0] rs2;
    logic [7:0] imm;
    logic [2:0] bank_rs_o;
    logic [2:0] bank_rs2_o;
    logic [7:0] bank_d1_i;
    logic [7:0] bank_d2_i;
    logic [2:0] bank_rd_o;
    logic [7:0] bank_dat_o;
    logic       bank_we_o;
    logic       done;
    logic [7:0] res_o;
    logic       zero_o;
    logic       carry_o;

    always #5 clkg = ~clkg;

    regbank_seq dut (
        .clkg        (clkg),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .op          (op),
        .rd          (rd),
        .rs          (rs),
        .rs2         (rs2),
        .imm         (imm),
        .bank_rs_o   (bank_rs_o),
        .bank_rs2_o  (bank_rs2_o),
        .bank_d1_i   (bank_d1_i),
        .bank_d2_i   (bank_d2_i),
        .bank_rd_o   (bank_rd_o),
        .bank_dat_o  (bank_dat_o),
        .bank_we_o   (bank_we_o),
        .done        (done),
        .res_o       (res_o),
        .zero_o      (zero_o),
        .carry_o     (carry_o)
    );

    // register bank environment
    logic [7:0] bank [8];
    assign bank_d1_i = bank[bank_rs_o];
    assign bank_d2_i = bank[bank_rs2_o];

    always @(posedge clkg or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) bank[i] <= 8'h00;
        end else if (bank_we_o) begin
            bank[bank_rd_o] <= bank_dat_o;
        end
    end

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_acc = 0;

    always @(posedge clkg) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // reference model: architectural registers and flags
    typedef struct {
        bit       we;
        int       rd;
        int       dat;
        bit       z;
        bit       c;
    } exp_t;

    exp_t q[$];
    int   m_regs[8];
    bit   m_z;
    bit   m_c;

    function automatic void model_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = 0;
        m_z = 1'b0;
        m_c = 1'b0;
        q.delete();
    endfunction

    function automatic void predict(int o, int d, int s1, int s2, int im);
        int   a = m_regs[s1];
        int   b = m_regs[s2];
        int   r = 0;
        bit   c = 1'b0;
        exp_t e;
        case (o)
            0: begin r = a + b; c = (r > 255); end
            1, 7: begin r = a - b; c = (a < b); end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: begin r = a * 2; c = (a >= 128); end
            default: r = im;
        endcase
        r = r & 255;
        if (o != 6 && FLAGS) begin
            m_z = (r == 0);
            m_c = c;
        end
        if (o != 7) m_regs[d] = r;
        e.we  = (o != 7);
        e.rd  = d;
        e.dat = r;
        e.z   = m_z;
        e.c   = m_c;
        q.push_back(e);
    endfunction

    // monitor: compare every writeback against the scoreboard
    bit pend = 1'b0;
    int pend_rd;
    int pend_dat;

    always @(negedge clkg) begin
        exp_t e;
        if (rst) begin
            pend = 1'b0;
        end else begin
            if (pend) begin
                chk("bank_content", bank[pend_rd], pend_dat);
                pend = 1'b0;
            end
            if (done) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("we", bank_we_o, e.we);
                    chk("ready_in_wb", instr_ready, 0);
                    chk("res_o", res_o, e.dat);
                    chk("zero_o", zero_o, e.z);
                    chk("carry_o", carry_o, e.c);
                    if (e.we) begin
                        chk("wr_addr", bank_rd_o, e.rd);
                        chk("wr_data", bank_dat_o, e.dat);
                        pend     = 1'b1;
                        pend_rd  = e.rd;
                        pend_dat = e.dat;
                    end
                end
            end
        end
    end

    task automatic issue(input int o, input int d, input int s1,
                         input int s2, input int im, input bit keep);
        int n = 0;
        @(negedge clkg);
        op          = 3'(o);
        rd          = 3'(d);
        rs          = 3'(s1);
        rs2         = 3'(s2);
        imm         = 8'(im);
        instr_valid = 1'b1;
        while (!instr_ready && n < 20) begin
            @(negedge clkg);
            n++;
        end
        if (!instr_ready) begin
            chk("accept_timeout", 0, 1);
            instr_valid = 1'b0;
        end else begin
            predict(o, d, s1, s2, im);
            @(posedge clkg);
            #1;
            last_acc = cyc;
            if (!keep) instr_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || pend) && n < 20) begin
            @(negedge clkg);
            n++;
        end
        @(negedge clkg);
        chk("drain", q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int prev;
        int n;
        rst         = 1'b1;
        instr_valid = 1'b0;
        op          = '0;
        rd          = '0;
        rs          = '0;
        rs2         = '0;
        imm         = '0;
        model_reset();
        repeat (3) @(negedge clkg);
        chk("rst_ready", instr_ready, 1);
        chk("rst_we", bank_we_o, 0);
        chk("rst_done", done, 0);
        chk("rst_res", res_o, 0);
        chk("rst_zero", zero_o, 0);
        chk("rst_carry", carry_o, 0);
        rst = 1'b0;

        issue(6, 1, 0, 0, 8'h0F, 0);
        issue(6, 2, 0, 0, 8'hF3, 0);
        issue(0, 3, 1, 2, 0, 0);
        issue(1, 4, 1, 1, 0, 0);
        issue(7, 4, 1, 2, 0, 0);
        drain();
        chk("r3_add", bank[3], 8'h02);
        chk("r4_sub", bank[4], 8'h00);

        // back-to-back with valid held high
        issue(4, 7, 1, 2, 0, 1);
        prev = last_acc;
        issue(3, 0, 3, 1, 0, 1);
        chk("gap1", last_acc - prev, 3);
        prev = last_acc;
        issue(2, 7, 7, 2, 0, 0);
        chk("gap2", last_acc - prev, 3);

        issue(5, 5, 2, 0, 0, 0);
        issue(0, 5, 5, 5, 0, 0);
        drain();
        chk("r5_shl_add", bank[5], 8'hCC);

        for (int i = 0; i < 40; i++) begin
            issue($urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 255), $urandom_range(0, 1) == 1);
            if ($urandom_range(0, 3) == 0) begin
                instr_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clkg);
            end
        end
        instr_valid = 1'b0;
        drain();
        for (int i = 0; i < 8; i++) chk("bank_final", bank[i], m_regs[i]);

        // reset landing in WB
        issue(6, 6, 0, 0, 8'hAA, 0);
        n = 0;
        while (!done && n < 10) begin
            @(negedge clkg);
            n++;
        end
        chk("wb_reached", done, 1);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("mid_rst_we", bank_we_o, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_ready", instr_ready, 1);
        chk("mid_rst_res", res_o, 0);
        chk("mid_rst_zero", zero_o, 0);
        chk("mid_rst_carry", carry_o, 0);
        repeat (2) @(negedge clkg);
        chk("r6_dropped", bank[6], 0);
        rst = 1'b0;

        issue(6, 6, 0, 0, 8'h5A, 0);
        issue(4, 7, 6, 6, 0, 0);
        drain();
        for (int i = 0; i < 8; i++) chk("bank_post", bank[i], m_regs[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
